// File: rtl/up_down_counter_pkg.sv
// Shared types and defaults for the up/down counter.
// Optional build macro used by this block: UP_DOWN_COUNTER_SATURATE_EN.
package up_down_counter_pkg;

  localparam int UDC_DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    DIR_HOLD = 2'd0,
    DIR_UP   = 2'd1,
    DIR_DOWN = 2'd2
  } count_dir_t;

endpackage

// File: rtl/udc_next_count.sv
// Combinational next-count logic for the up/down counter.
// Wraps modulo 2^WIDTH by default; saturates when UP_DOWN_COUNTER_SATURATE_EN is defined.
module udc_next_count
  import up_down_counter_pkg::*;
#(
  parameter int WIDTH = UDC_DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] count,
  input  count_dir_t       dir,
  output logic [WIDTH-1:0] next_count
);

  localparam logic [WIDTH-1:0] COUNT_MAX = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] COUNT_MIN = '0;
  localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);

  always_comb begin
    next_count = count;
    case (dir)
      DIR_UP: begin
`ifdef UP_DOWN_COUNTER_SATURATE_EN
        next_count = (count == COUNT_MAX) ? COUNT_MAX : count + ONE;
`else
        next_count = count + ONE;
`endif
      end
      DIR_DOWN: begin
`ifdef UP_DOWN_COUNTER_SATURATE_EN
        next_count = (count == COUNT_MIN) ? COUNT_MIN : count - ONE;
`else
        next_count = count - ONE;
`endif
      end
      default: next_count = count;
    endcase
  end

endmodule

// File: rtl/up_down_counter_4bit.sv
// Synchronous up/down counter with synchronous clear and terminal-count flags.
// Define UP_DOWN_COUNTER_SATURATE_EN to saturate at the bounds instead of wrapping.
module up_down_counter_4bit
  import up_down_counter_pkg::*;
#(
  parameter int WIDTH = UDC_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             Up,
  input  logic             Down,
  output logic [WIDTH-1:0] Out,
  output logic             at_max,
  output logic             at_min
);

  count_dir_t       dir;
  logic [WIDTH-1:0] next_count;

  // Both requests together cancel out and hold the count.
  always_comb begin
    dir = DIR_HOLD;
    if (Up && !Down) begin
      dir = DIR_UP;
    end else if (Down && !Up) begin
      dir = DIR_DOWN;
    end
  end

  udc_next_count #(
    .WIDTH(WIDTH)
  ) u_next (
    .count      (Out),
    .dir        (dir),
    .next_count (next_count)
  );

  always_ff @(posedge clk) begin
    if (clear) begin
      Out <= '0;
    end else begin
      Out <= next_count;
    end
  end

  assign at_max = (Out == {WIDTH{1'b1}});
  assign at_min = (Out == '0);

endmodule

// File: tb/tb_up_down_counter_4bit.sv
// Self-checking bench for up_down_counter_4bit: directed steps plus a short random tail,
// with a reference model feeding an expected queue of {Out, at_max, at_min}.
module tb_up_down_counter_4bit;

  localparam int W = 4;
  localparam int MAXV = (1 << W) - 1;

  logic         clk;
  logic         clear;
  logic         up;
  logic         down;
  logic [W-1:0] out;
  logic         at_max;
  logic         at_min;

  logic [W+1:0] exp_q[$];
  int           model_cnt;
  int           n_checks;
  int           n_fails;

  up_down_counter_4bit dut (
    .clk    (clk),
    .clear  (clear),
    .Up     (up),
    .Down   (down),
    .Out    (out),
    .at_max (at_max),
    .at_min (at_min)
  );

  // clock / reset-free start: clear is driven by the steps
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [W+1:0] obs, input logic [W+1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference behaviour written from the counter's contract in integer arithmetic.
  function automatic int model_next(input int cur, input logic c, input logic u, input logic d);
    int nxt;
    nxt = cur;
    if (c) begin
      nxt = 0;
    end else if (u && !d) begin
`ifdef UP_DOWN_COUNTER_SATURATE_EN
      nxt = (cur == MAXV) ? MAXV : cur + 1;
`else
      nxt = (cur + 1) % (MAXV + 1);
`endif
    end else if (d && !u) begin
`ifdef UP_DOWN_COUNTER_SATURATE_EN
      nxt = (cur == 0) ? 0 : cur - 1;
`else
      nxt = (cur + MAXV) % (MAXV + 1);
`endif
    end
    return nxt;
  endfunction

  // Drive one edge's worth of inputs, push the expectation, then compare after the edge.
  task automatic step(input string tag, input logic c, input logic u, input logic d);
    logic [W+1:0] e;
    @(negedge clk);
    clear = c;
    up    = u;
    down  = d;
    model_cnt = model_next(model_cnt, c, u, d);
    e = {W'(model_cnt), (model_cnt == MAXV), (model_cnt == 0)};
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fails++;
      $error("FAIL %s scoreboard empty", tag);
    end else begin
      check(tag, {out, at_max, at_min}, exp_q.pop_front());
    end
  endtask

  task automatic check_out(input string tag, input int value);
    check(tag, {out, at_max, at_min}, {W'(value), (value == MAXV), (value == 0)});
  endtask

  initial begin
    clear = 1'b0;
    up    = 1'b0;
    down  = 1'b0;
    model_cnt = 0;
    n_checks  = 0;
    n_fails   = 0;

    // reset with Up asserted: clear wins
    step("reset0", 1'b1, 1'b1, 1'b0);
    step("reset1", 1'b1, 1'b1, 1'b0);
    check_out("reset_const", 0);

    // count up through the top and across the boundary
    for (int i = 1; i <= 15; i++) step("count_up", 1'b0, 1'b1, 1'b0);
    check_out("up_at_15", 15);
    step("up_16th", 1'b0, 1'b1, 1'b0);
`ifdef UP_DOWN_COUNTER_SATURATE_EN
    check_out("up_saturate", 15);
`else
    check_out("up_wrap", 0);
`endif

    // direction switch: 0 -> 8 then down 7,6,5,4
    step("clr_a", 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) step("up_to_8", 1'b0, 1'b1, 1'b0);
    check_out("at_8", 8);
    for (int i = 0; i < 4; i++) step("down_from_8", 1'b0, 1'b0, 1'b1);
    check_out("down_to_4", 4);

    // down from zero
    step("clr_b", 1'b1, 1'b0, 1'b0);
    step("down_from_0", 1'b0, 1'b0, 1'b1);
`ifdef UP_DOWN_COUNTER_SATURATE_EN
    check_out("down_saturate", 0);
`else
    check_out("down_wrap", 15);
`endif

    // hold with none and with both requests
    step("clr_c", 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step("up_to_5", 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step("hold_none", 1'b0, 1'b0, 1'b0);
    check_out("hold_none_5", 5);
    for (int i = 0; i < 3; i++) step("hold_both", 1'b0, 1'b1, 1'b1);
    check_out("hold_both_5", 5);

    // clear mid-count then resume
    step("clr_d", 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) step("up_to_9", 1'b0, 1'b1, 1'b0);
    check_out("at_9", 9);
    step("clear_mid", 1'b1, 1'b1, 1'b0);
    check_out("clear_mid_0", 0);
    step("resume", 1'b0, 1'b1, 1'b0);
    check_out("resume_1", 1);

    // random tail
    for (int i = 0; i < 60; i++) begin
      step("random", ($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    n_checks++;
    assert (exp_q.size() == 0) else begin
      n_fails++;
      $error("FAIL queue_drain observed=%0d expected=0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
